seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU slice, with the same 4-bit S operation encoding.
- Generalised to WIDTH bits. Adds multi-bit shift/rotate, executed iteratively one bit per cycle.
- Adds a registered flag set (C/Z/N/V) and valid/ready handshakes on input and output.
- Sits between the operand register file and the writeback stage; holds one operation at a time.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from B[SHW-1:0].

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept an operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; shift amount in B[SHW-1:0] for shift ops.
- S  input  4  operation select: S[3:2] group, S[1:0] function.
- C_in  input  1  carry in, arithmetic group only.
- A_l  input  1  serial fill bit entering the MSB on right shift.
- A_r  input  1  serial fill bit entering the LSB on left shift.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- O  output  WIDTH  result.
- C_out  output  1  carry flag.
- Z  output  1  zero flag, O==0.
- N  output  1  negative flag, O[WIDTH-1].
- V  output  1  signed overflow flag.

Behaviour:
- Reset (async, any state, including mid-shift): state=IDLE; O, C_out, Z, N, V, out_valid = 0; in_ready=1; internal count=0.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: in_valid && in_ready at a rising edge. A, B, S, C_in, A_l and A_r are all captured; later input changes are ignored.
- Arithmetic group (S[3:2]=00): O = A + D + C_in, with WIDTH-bit result, C_out = bit WIDTH of the sum, V = signed overflow of A + D.
  - D by S[1:0]: 00 B, 01 ~B, 10 0, 11 all-ones.
  - So 01 with C_in=1 gives A−B, and 11 with C_in=0 gives A−1.
- Logic group (01), bitwise: 00 A&B, 01 A|B, 10 A^B, 11 ~A. C_out=0, V=0.
- Shift group (1x):
  - S[2]=0 shifts right, S[2]=1 shifts left.
  - S[0]=0 fills: A_l enters the MSB (right shift), A_r enters the LSB (left shift).
  - S[0]=1 rotates: the bit leaving one end re-enters at the other.
  - S[1] is ignored.
  - Amount n = B[SHW-1:0]; values ≥WIDTH are not possible by construction.
- Latency:
  - Arithmetic, logic, and shift with n=0: result computed at the accept edge; IDLE→DONE; out_valid high on the next cycle (1-cycle latency).
  - Shift with n≥1: the accept edge loads acc=A and count=n, IDLE→SHIFT. Each later edge shifts acc by one and decrements count. The edge where count goes 1→0 performs the last shift, loads O and goes to DONE.
  - out_valid therefore rises n+1 cycles after the accept edge.
- Shift flags: C_out = the last bit shifted out of the register. For n=0, C_out=0. In rotate mode C_out still equals the last bit moved across the end. V=0.
- Z and N are derived from the final O for every operation and registered together with O.
- DONE:
  - O and flags are held stable while out_ready=0 (unlimited backpressure).
  - out_valid && out_ready → IDLE, out_valid=0 on the next cycle.
  - O and flags keep their last values until the next result load.
- No overlap: a new operation is accepted only in IDLE. in_valid is ignored in SHIFT/DONE, including the cycle in which the DONE handshake completes.
- in_valid while rst is asserted is ignored.

Test Plan (WIDTH=8):
- ADD: A=0x7F, B=0x01, S=0000, C_in=0 → one cycle after accept, out_valid=1, O=0x80, C_out=0, V=1, N=1, Z=0.
- SUB: A=0x05, B=0x05, S=0001, C_in=1 → O=0x00, C_out=1, Z=1, V=0, 1-cycle latency. Also A=0x80, B=0x01, S=0001, C_in=1 → O=0x7F, V=1.
- LOGIC: A=0xF0, B=0xFF, S=0110 → O=0x0F, C_out=0, V=0. S=0111 with A=0xF0 → O=0x0F.
- SHIFT RIGHT fill: A=0x81, B=0x03, S=1000, A_l=1 → in_ready=0 for the shift; out_valid rises 4 cycles after accept; O=0xF0, C_out=0, N=1. Repeat with S=1001 (rotate) → O=0x30, C_out=0.
- SHIFT LEFT n=0: A=0x3C, B=0x00, S=1100 → 1-cycle latency, O=0x3C, C_out=0. Then A=0x81, B=0x01, S=1100, A_r=0 → O=0x02, C_out=1.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE → O and flags unchanged, in_ready=0, extra in_valid pulses ignored. Then out_ready=1 → IDLE next cycle.
  - Assert rst two cycles into a B=5 shift → all outputs 0 immediately, in_ready=1. The next op completes normally.

Source files
------------

// File: rtl/seq_alu.sv
// ============================================================================
// Module   : seq_alu
// Brief    : Registered WIDTH-bit ALU with iterative shift/rotate, flags and
//            valid/ready handshakes; holds one operation at a time.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             C_in,
    input  logic             A_l,
    input  logic             A_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] O,
    output logic             C_out,
    output logic             Z,
    output logic             N,
    output logic             V
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [1:0] c_GRP_ARITH = 2'b00;
    localparam logic [1:0] c_GRP_LOGIC = 2'b01;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;

    logic             w_accept;
    logic             w_is_shift;
    logic [SHW-1:0]   w_amount;
    logic             w_immediate;

    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_count;
    logic             r_left;
    logic             r_rotate;
    logic             r_fill;

    logic [WIDTH-1:0] w_d;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_imm_o;
    logic             w_imm_c;
    logic             w_imm_v;

    logic [WIDTH-1:0] w_step_acc;
    logic             w_step_out;
    logic             w_last_step;

    assign w_accept    = in_valid && in_ready;
    assign w_is_shift  = S[3];
    assign w_amount    = B[SHW-1:0];
    assign w_immediate = !w_is_shift || (w_amount == '0);
    assign w_last_step = (r_count == SHW'(1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = w_immediate ? c_ST_DONE : c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (w_last_step) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (out_ready) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            c_ST_IDLE: in_ready  = 1'b1;
            c_ST_DONE: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle result: arithmetic, logic and zero-length shifts
    // ------------------------------------------------------------------
    always_comb begin
        w_d     = '0;
        w_sum   = '0;
        w_imm_o = A;
        w_imm_c = 1'b0;
        w_imm_v = 1'b0;
        case (S[3:2])
            c_GRP_ARITH: begin
                case (S[1:0])
                    2'b00:   w_d = B;
                    2'b01:   w_d = ~B;
                    2'b10:   w_d = '0;
                    default: w_d = '1;
                endcase
                w_sum   = {1'b0, A} + {1'b0, w_d} + {{WIDTH{1'b0}}, C_in};
                w_imm_o = w_sum[WIDTH-1:0];
                w_imm_c = w_sum[WIDTH];
                // Overflow: like-signed operands producing an opposite-signed result
                w_imm_v = (A[WIDTH-1] == w_d[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            c_GRP_LOGIC: begin
                case (S[1:0])
                    2'b00:   w_imm_o = A & B;
                    2'b01:   w_imm_o = A | B;
                    2'b10:   w_imm_o = A ^ B;
                    default: w_imm_o = ~A;
                endcase
            end
            default: begin
                w_imm_o = A;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // One-bit shift step applied to the accumulator
    // ------------------------------------------------------------------
    always_comb begin
        if (r_left) begin
            w_step_out = r_acc[WIDTH-1];
            w_step_acc = {r_acc[WIDTH-2:0], (r_rotate ? r_acc[WIDTH-1] : r_fill)};
        end else begin
            w_step_out = r_acc[0];
            w_step_acc = {(r_rotate ? r_acc[0] : r_fill), r_acc[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers and result/flag capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_count  <= '0;
            r_left   <= 1'b0;
            r_rotate <= 1'b0;
            r_fill   <= 1'b0;
            O        <= '0;
            C_out    <= 1'b0;
            Z        <= 1'b0;
            N        <= 1'b0;
            V        <= 1'b0;
        end else if (w_accept) begin
            // All operand and mode bits are captured so later input changes are ignored
            r_acc    <= A;
            r_count  <= w_amount;
            r_left   <= S[2];
            r_rotate <= S[0];
            r_fill   <= S[2] ? A_r : A_l;
            if (w_immediate) begin
                O     <= w_imm_o;
                C_out <= w_imm_c;
                Z     <= (w_imm_o == '0);
                N     <= w_imm_o[WIDTH-1];
                V     <= w_imm_v;
            end
        end else if (r_state == c_ST_SHIFT) begin
            r_acc   <= w_step_acc;
            r_count <= r_count - SHW'(1);
            if (w_last_step) begin
                O     <= w_step_acc;
                C_out <= w_step_out;
                Z     <= (w_step_acc == '0);
                N     <= w_step_acc[WIDTH-1];
                V     <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module   : tb_seq_alu
// Brief    : Directed self-checking bench for seq_alu (WIDTH=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   S = '0;
    logic         C_in = 1'b0;
    logic         A_l = 1'b0;
    logic         A_r = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] O;
    logic         C_out;
    logic         Z;
    logic         N;
    logic         V;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .S         (S),
        .C_in      (C_in),
        .A_l       (A_l),
        .A_r       (A_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .O         (O),
        .C_out     (C_out),
        .Z         (Z),
        .N         (N),
        .V         (V)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble inputs after the accept edge, wait for the
    // result and compare it. exp_lat counts edges after the accept edge.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic cin, input logic al, input logic ar,
                          input int exp_lat, input logic [W-1:0] exp_o,
                          input logic exp_c, input logic exp_v);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready_before"}, 32'(in_ready), 32'd1);
        A = a; B = b; S = s; C_in = cin; A_l = al; A_r = ar;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = W'($urandom); B = W'($urandom); S = 4'($urandom);
        C_in = 1'($urandom); A_l = 1'($urandom); A_r = 1'($urandom);
        if (exp_lat > 0) begin
            check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
            check({tag, ".out_valid_busy"}, 32'(out_valid), 32'd0);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".O"}, 32'(O), 32'(exp_o));
        check({tag, ".C_out"}, 32'(C_out), 32'(exp_c));
        check({tag, ".V"}, 32'(V), 32'(exp_v));
        check({tag, ".Z"}, 32'(Z), 32'(exp_o == '0));
        check({tag, ".N"}, 32'(N), 32'(exp_o[W-1]));
        check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset with a request pending: it must be ignored
        in_valid = 1'b1;
        A = 8'h12; B = 8'h34; S = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.O", 32'(O), 32'd0);
        check("rst.flags", {28'd0, C_out, Z, N, V}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst.in_ready", 32'(in_ready), 32'd1);
        check("post_rst.out_valid", 32'(out_valid), 32'd0);

        // Arithmetic group
        run_op("add_ovf",  8'h7F, 8'h01, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 8'h80, 1'b0, 1'b1);
        consume("add_ovf");
        run_op("sub_zero", 8'h05, 8'h05, 4'b0001, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        consume("sub_zero");
        run_op("sub_ovf",  8'h80, 8'h01, 4'b0001, 1'b1, 1'b0, 1'b0, 0, 8'h7F, 1'b1, 1'b1);
        consume("sub_ovf");
        run_op("inc_wrap", 8'hFF, 8'h55, 4'b0010, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        consume("inc_wrap");
        run_op("dec_zero", 8'h00, 8'h55, 4'b0011, 1'b0, 1'b0, 1'b0, 0, 8'hFF, 1'b0, 1'b0);
        consume("dec_zero");

        // Logic group
        run_op("xor",      8'hF0, 8'hFF, 4'b0110, 1'b1, 1'b0, 1'b0, 0, 8'h0F, 1'b0, 1'b0);
        consume("xor");
        run_op("not",      8'hF0, 8'h00, 4'b0111, 1'b1, 1'b0, 1'b0, 0, 8'h0F, 1'b0, 1'b0);
        consume("not");
        run_op("or",       8'hF0, 8'h3C, 4'b0101, 1'b0, 1'b0, 1'b0, 0, 8'hFC, 1'b0, 1'b0);
        consume("or");

        // Shift group
        run_op("shr_fill", 8'h81, 8'h03, 4'b1000, 1'b0, 1'b1, 1'b0, 3, 8'hF0, 1'b0, 1'b0);
        consume("shr_fill");
        run_op("shr_rot",  8'h81, 8'h03, 4'b1001, 1'b0, 1'b1, 1'b0, 3, 8'h30, 1'b0, 1'b0);
        consume("shr_rot");
        run_op("shl_n0",   8'h3C, 8'h00, 4'b1100, 1'b0, 1'b0, 1'b1, 0, 8'h3C, 1'b0, 1'b0);
        consume("shl_n0");
        run_op("shl_n1",   8'h81, 8'h01, 4'b1100, 1'b0, 1'b0, 1'b0, 1, 8'h02, 1'b1, 1'b0);
        consume("shl_n1");
        run_op("shl_rot",  8'h81, 8'hFA, 4'b1111, 1'b0, 1'b0, 1'b0, 2, 8'h06, 1'b0, 1'b0);
        consume("shl_rot");
        run_op("shr_zero", 8'h01, 8'h01, 4'b1010, 1'b0, 1'b0, 1'b1, 1, 8'h00, 1'b1, 1'b0);
        consume("shr_zero");

        // Backpressure: result held, extra requests ignored
        run_op("bp_and",   8'hF0, 8'h3C, 4'b0100, 1'b1, 1'b0, 1'b0, 0, 8'h30, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            A = 8'hAA; B = 8'h55; S = 4'b0000;
            @(posedge clk);
            #1;
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.in_ready", 32'(in_ready), 32'd0);
            check("bp.O", 32'(O), 32'h30);
            check("bp.flags", {28'd0, C_out, Z, N, V}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("bp_release.out_valid", 32'(out_valid), 32'd0);
        check("bp_release.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp_release.no_accept", 32'(in_ready), 32'd1);
        check("bp_release.O_kept", 32'(O), 32'h30);

        // Asynchronous reset two cycles into a 5-bit shift
        @(negedge clk);
        A = 8'hAA; B = 8'h05; S = 4'b1000; A_l = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mid_rst.busy", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst.O", 32'(O), 32'd0);
        check("mid_rst.flags", {28'd0, C_out, Z, N, V}, 32'd0);
        check("mid_rst.in_ready", 32'(in_ready), 32'd1);
        check("mid_rst.out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 8'h12, 8'h34, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 8'h46, 1'b0, 1'b0);
        consume("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
